munoc_apb2axi_bridge: RTL
=========================

Name: munoc_apb2axi_bridge

Overview:
- APB completer to single-beat AXI manager bridge. The reverse of the NoC's AXI-to-APB slave conversion.
- Lets an APB-side requester, such as a debug or control master, reach the NoC through an AXI master network interface.
- Each APB access becomes exactly one AXI transaction: len=0, INCR burst, full-width size. There is only one outstanding transaction at a time.

Parameters:
- BW_ADDR, 32, address width on both sides.
- BW_DATA, 32, data width on both sides; must be 32 or 64.
- BW_AXI_TID, 4, AXI ID width.
- AXI_TID_VALUE, 0, constant ID driven on awid, wid and arid.

Ports:
clk  in  1  clock
rstnn  in  1  asynchronous active-low reset
spaddr  in  BW_ADDR  APB address
spwrite  in  1  APB direction, 1=write
spsel  in  1  APB select
spenable  in  1  APB access phase
spwdata  in  BW_DATA  APB write data
spwstrb  in  BW_DATA/8  APB write strobes
sprdata  out  BW_DATA  APB read data
spready  out  1  APB ready
spslverr  out  1  APB error
mxawid/mxawaddr/mxawlen/mxawsize/mxawburst  out  BW_AXI_TID/BW_ADDR/BW_AXI_ALEN/BW_AXI_ASIZE/BW_AXI_ABURST  AW payload
mxawvalid  out  1 ; mxawready  in  1  AW handshake
mxwid/mxwdata/mxwstrb/mxwlast  out  BW_AXI_TID/BW_DATA/BW_DATA/8/1  W payload
mxwvalid  out  1 ; mxwready  in  1  W handshake
mxbid/mxbresp  in  BW_AXI_TID/BW_AXI_BRESP  B payload
mxbvalid  in  1 ; mxbready  out  1  B handshake
mxarid/mxaraddr/mxarlen/mxarsize/mxarburst  out  (as AW)  AR payload
mxarvalid  out  1 ; mxarready  in  1  AR handshake
mxrid/mxrdata/mxrresp/mxrlast  in  BW_AXI_TID/BW_DATA/BW_AXI_RRESP/1  R payload
mxrvalid  in  1 ; mxrready  out  1  R handshake

Behaviour:
- States: IDLE, WREQ, BWAIT, RREQ, RWAIT, DONE.
- Reset values: state=IDLE; all valid/ready outputs 0; sprdata=0; spslverr=0; spready=0; captured address/data/strobe registers 0.
- Constant fields: len=0, burst=INCR (2'b01), size=log2(BW_DATA/8), wlast=1, IDs=AXI_TID_VALUE. Addresses pass through unmodified.
- IDLE: when spsel&spenable&!spready, capture spaddr, spwdata and spwstrb.
  - spwrite=1: go to WREQ; mxawvalid=1 and mxwvalid=1 from the next cycle.
  - spwrite=0: go to RREQ; mxarvalid=1.
- WREQ:
  - mxawvalid clears on the AW handshake; mxwvalid clears on the W handshake. The two are independent and either order is legal.
  - Handshakes in the same cycle clear both.
  - Leave WREQ for BWAIT in the cycle after both handshakes are done.
  - Payload stays stable while valid is high.
- BWAIT: mxbready=1. When mxbvalid, capture spslverr=mxbresp[1] and go to DONE.
- RREQ: hold mxarvalid until mxarready, then go to RWAIT.
- RWAIT: mxrready=1. When mxrvalid, capture sprdata=mxrdata and spslverr=mxrresp[1], then go to DONE. mxrlast is ignored; it is always 1.
- DONE:
  - spready=1 for exactly one cycle, then IDLE.
  - sprdata and spslverr hold their value until the next DONE.
  - sprdata is unchanged on writes.
- The !spready guard stops the completing APB access from re-launching. A new access is accepted at the earliest 1 cycle after DONE.
- Minimum APB latency with zero-wait AXI: write 4 cycles from access-phase sample to spready; read 4 cycles.
- An mxbvalid or mxrvalid that arrives outside BWAIT/RWAIT is not accepted, because ready stays 0.
- Response IDs are not checked.
- APB protocol violation (spsel or spenable dropping mid-transaction): ignored; the AXI transaction completes and spready still pulses.
- Reset mid-operation: immediate return to reset values. Any AXI transaction already issued is abandoned; the system must reset the fabric together with the bridge.

Test Plan:
- Write 0x1000_0040 data 0xDEAD_BEEF strb 0xF, AW and W ready immediately, bresp=OKAY → one AW with len=0, size=2, burst=1, wlast=1; spready pulses 1 cycle 4 cycles after access; spslverr=0.
- Read 0x1000_0044, arready delayed 3 cycles, rdata 0x1234_5678 rresp=OKAY → mxarvalid held stable 4 cycles; sprdata=0x1234_5678; spslverr=0.
- Write with W handshake 2 cycles before AW handshake, then the reverse order, then both in the same cycle → exactly one AW and one W each time; no duplicate valid after handshake.
- Read with rresp=SLVERR (2'b10), then write with bresp=DECERR (2'b11) → spslverr=1 on both spready pulses.
- Back-to-back APB writes held with spsel&spenable through completion → exactly one AXI transaction per APB access; no relaunch on the spready cycle.
- Assert rstnn=0 during BWAIT → all valid/ready outputs go to 0 asynchronously; after release, a new read completes normally.

Source files
------------

// File: rtl/munoc_apb2axi_bridge.sv
// APB completer to single-beat AXI manager bridge: each APB access becomes
// exactly one len=0 INCR AXI transaction, with one transaction in flight at a time.
module munoc_apb2axi_bridge #(
    parameter int BW_ADDR       = 32,
    parameter int BW_DATA       = 32,
    parameter int BW_AXI_TID    = 4,
    parameter int AXI_TID_VALUE = 0,
    parameter int BW_AXI_ALEN   = 8,
    parameter int BW_AXI_ASIZE  = 3,
    parameter int BW_AXI_ABURST = 2,
    parameter int BW_AXI_BRESP  = 2,
    parameter int BW_AXI_RRESP  = 2
) (
    input  logic                     clk,
    input  logic                     rstnn,
    // APB completer
    input  logic [BW_ADDR-1:0]       spaddr,
    input  logic                     spwrite,
    input  logic                     spsel,
    input  logic                     spenable,
    input  logic [BW_DATA-1:0]       spwdata,
    input  logic [BW_DATA/8-1:0]     spwstrb,
    output logic [BW_DATA-1:0]       sprdata,
    output logic                     spready,
    output logic                     spslverr,
    // AXI write address
    output logic [BW_AXI_TID-1:0]    mxawid,
    output logic [BW_ADDR-1:0]       mxawaddr,
    output logic [BW_AXI_ALEN-1:0]   mxawlen,
    output logic [BW_AXI_ASIZE-1:0]  mxawsize,
    output logic [BW_AXI_ABURST-1:0] mxawburst,
    output logic                     mxawvalid,
    input  logic                     mxawready,
    // AXI write data
    output logic [BW_AXI_TID-1:0]    mxwid,
    output logic [BW_DATA-1:0]       mxwdata,
    output logic [BW_DATA/8-1:0]     mxwstrb,
    output logic                     mxwlast,
    output logic                     mxwvalid,
    input  logic                     mxwready,
    // AXI write response
    input  logic [BW_AXI_TID-1:0]    mxbid,
    input  logic [BW_AXI_BRESP-1:0]  mxbresp,
    input  logic                     mxbvalid,
    output logic                     mxbready,
    // AXI read address
    output logic [BW_AXI_TID-1:0]    mxarid,
    output logic [BW_ADDR-1:0]       mxaraddr,
    output logic [BW_AXI_ALEN-1:0]   mxarlen,
    output logic [BW_AXI_ASIZE-1:0]  mxarsize,
    output logic [BW_AXI_ABURST-1:0] mxarburst,
    output logic                     mxarvalid,
    input  logic                     mxarready,
    // AXI read data
    input  logic [BW_AXI_TID-1:0]    mxrid,
    input  logic [BW_DATA-1:0]       mxrdata,
    input  logic [BW_AXI_RRESP-1:0]  mxrresp,
    input  logic                     mxrlast,
    input  logic                     mxrvalid,
    output logic                     mxrready
);

    localparam logic [BW_AXI_TID-1:0]    TID     = BW_AXI_TID'(AXI_TID_VALUE);
    localparam logic [BW_AXI_ASIZE-1:0]  AX_SIZE = BW_AXI_ASIZE'((BW_DATA == 64) ? 3 : 2);
    localparam logic [BW_AXI_ABURST-1:0] AX_INCR = BW_AXI_ABURST'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        BWAIT = 3'd2,
        RREQ  = 3'd3,
        RWAIT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state;
    logic [BW_ADDR-1:0]   addr_q;
    logic [BW_DATA-1:0]   wdata_q;
    logic [BW_DATA/8-1:0] wstrb_q;

    // Payload comes only from registers captured in IDLE, so it stays stable under valid.
    assign mxawid    = TID;
    assign mxawaddr  = addr_q;
    assign mxawlen   = '0;
    assign mxawsize  = AX_SIZE;
    assign mxawburst = AX_INCR;

    assign mxwid     = TID;
    assign mxwdata   = wdata_q;
    assign mxwstrb   = wstrb_q;
    assign mxwlast   = 1'b1;

    assign mxarid    = TID;
    assign mxaraddr  = addr_q;
    assign mxarlen   = '0;
    assign mxarsize  = AX_SIZE;
    assign mxarburst = AX_INCR;

    // Response IDs, rlast and the low response bit carry no information for this bridge.
    logic unused_resp;
    assign unused_resp = ^{mxbid, mxbresp, mxrid, mxrresp, mxrlast};

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            mxawvalid <= 1'b0;
            mxwvalid  <= 1'b0;
            mxarvalid <= 1'b0;
            mxbready  <= 1'b0;
            mxrready  <= 1'b0;
            spready   <= 1'b0;
            spslverr  <= 1'b0;
            sprdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // !spready keeps the completing access from launching a second transaction.
                    if (spsel && spenable && !spready) begin
                        addr_q  <= spaddr;
                        wdata_q <= spwdata;
                        wstrb_q <= spwstrb;
                        if (spwrite) begin
                            state     <= WREQ;
                            mxawvalid <= 1'b1;
                            mxwvalid  <= 1'b1;
                        end else begin
                            state     <= RREQ;
                            mxarvalid <= 1'b1;
                        end
                    end
                end
                WREQ: begin
                    // AW and W retire independently; move on once both valids are down.
                    if (mxawvalid && mxawready) mxawvalid <= 1'b0;
                    if (mxwvalid && mxwready)   mxwvalid  <= 1'b0;
                    if (!mxawvalid && !mxwvalid) begin
                        state    <= BWAIT;
                        mxbready <= 1'b1;
                    end
                end
                BWAIT: begin
                    if (mxbvalid) begin
                        mxbready <= 1'b0;
                        spslverr <= mxbresp[1];
                        spready  <= 1'b1;
                        state    <= DONE;
                    end
                end
                RREQ: begin
                    if (mxarvalid) begin
                        if (mxarready) mxarvalid <= 1'b0;
                    end else begin
                        state    <= RWAIT;
                        mxrready <= 1'b1;
                    end
                end
                RWAIT: begin
                    if (mxrvalid) begin
                        mxrready <= 1'b0;
                        sprdata  <= mxrdata;
                        spslverr <= mxrresp[1];
                        spready  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    spready <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
